// File: rtl/medidor_pkg.sv
// Shared types and helpers for the multi-channel bias meter.
package medidor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int unsigned MAX_RESOL_DEF = 24;
    localparam int unsigned CNT_W         = MAX_RESOL_DEF + 1;

    // Ceiling log2, never less than 1 so single-channel builds keep a 1-bit index.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/medidor_bias_multi_sync.sv
// N-bit multi-stage synchroniser for the raw oscillator samples; STAGES=0 is a pass-through.
module sync_vec #(
    parameter int unsigned N      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_sync
            logic [N-1:0] stg_q [STAGES];
            logic [N-1:0] stg_d [STAGES];

            always_comb begin
                stg_d[0] = d;
                for (int k = 1; k < STAGES; k++) stg_d[k] = stg_q[k-1];
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
                end else begin
                    for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
                end
            end

            assign q = stg_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/medidor_bias_multi.sv
// Multi-channel GARO bias meter: counts ones per channel over 2^r cycles and
// serialises each result set one channel per valid/ready beat.
module medidor_bias_multi
    import medidor_pkg::*;
#(
    parameter  int unsigned N_CH        = 4,
    parameter  int unsigned OUT_WIDTH   = 32,
    parameter  int unsigned MAX_RESOL   = 24,
    parameter  int unsigned RES_W       = 5,
    parameter  int unsigned SYNC_STAGES = 2,
    localparam int unsigned CH_W        = clog2_min1(N_CH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 continuo,
    input  logic [N_CH-1:0]      muestra,
    input  logic [RES_W-1:0]     resol,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 lock,
    output logic                 overrun
);

    localparam int unsigned CW = MAX_RESOL + 1;

    logic [N_CH-1:0]      ms;
    state_e               state_q, state_d;
    logic [RES_W-1:0]     r_q, r_d, r_in_c;
    logic [MAX_RESOL-1:0] win_q, win_d, win_mask_c;
    logic                 busy_q, busy_d;
    logic [CH_W-1:0]      ptr_q, ptr_d, nxt_c;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 lock_q, lock_d;
    logic                 ovr_q, ovr_d;
    logic                 cnt_clr_c, cnt_inc_c;
    logic                 snap_c, load_c, hs_c, last_beat_c;
    logic [N_CH*CW-1:0]   sum_flat, sh_flat;

    sync_vec #(.N(N_CH), .STAGES(SYNC_STAGES)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (muestra),
        .q       (ms)
    );

    assign r_in_c      = (resol > RES_W'(MAX_RESOL)) ? RES_W'(MAX_RESOL) : resol;
    assign win_mask_c  = ~({MAX_RESOL{1'b1}} << r_q);
    assign snap_c      = enable && (state_q == MEASURE) && (win_q == win_mask_c);
    assign load_c      = snap_c && !busy_q;
    assign hs_c        = busy_q && out_ready;
    assign last_beat_c = hs_c && (ptr_q == CH_W'(N_CH - 1));
    assign nxt_c       = CH_W'(ptr_q + 1'b1);

    // Per-channel ones counter and snapshot shadow register.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d, sh_q, sh_d, sum_c;

        always_comb begin
            sum_c = cnt_q + CW'(ms[g]);
            cnt_d = cnt_q;
            sh_d  = sh_q;
            if (cnt_clr_c)      cnt_d = '0;
            else if (cnt_inc_c) cnt_d = sum_c;
            if (!enable)        sh_d = '0;
            else if (load_c)    sh_d = sum_c;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                sh_q  <= '0;
            end else begin
                cnt_q <= cnt_d;
                sh_q  <= sh_d;
            end
        end

        assign sum_flat[g*CW +: CW] = sum_c;
        assign sh_flat[g*CW +: CW]  = sh_q;
    end

    // Window sequencing plus the drain engine, which runs alongside MEASURE in continuous mode.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        win_d      = win_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        lock_d     = lock_q;
        ovr_d      = ovr_q;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            win_d      = '0;
            cnt_clr_c  = 1'b1;
            busy_d     = 1'b0;
            ptr_d      = '0;
            out_data_d = '0;
            lock_d     = 1'b0;
            ovr_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    r_d       = r_in_c;
                    win_d     = '0;
                    cnt_clr_c = 1'b1;
                    state_d   = MEASURE;
                end
                MEASURE: begin
                    cnt_inc_c = 1'b1;
                    win_d     = win_q + MAX_RESOL'(1);
                    if (snap_c) begin
                        cnt_clr_c = 1'b1;
                        win_d     = '0;
                        if (continuo) r_d = r_in_c;
                        else          state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_beat_c || !busy_q) state_d = DONE;
                end
                default: ;
            endcase

            if (hs_c) begin
                if (last_beat_c) begin
                    busy_d = 1'b0;
                    ptr_d  = '0;
                end else begin
                    ptr_d      = nxt_c;
                    out_data_d = OUT_WIDTH'(sh_flat[nxt_c*CW +: CW]);
                end
            end

            if (load_c) begin
                busy_d     = 1'b1;
                ptr_d      = '0;
                out_data_d = OUT_WIDTH'(sum_flat[CW-1:0]);
                lock_d     = 1'b1;
            end else if (snap_c) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            win_q      <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            out_data_q <= '0;
            lock_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            win_q      <= win_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            lock_q     <= lock_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = ptr_q;
    assign out_valid = busy_q;
    assign lock      = lock_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_medidor_bias_multi.sv
// Directed bench for medidor_bias_multi with a beat scoreboard (reduced MAX_RESOL=6 build).
module tb_medidor_bias_multi;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        continuo;
    logic [3:0]  mbase;
    logic        tog = 1'b0;
    logic        tog_en;
    logic [3:0]  muestra;
    logic [4:0]  resol;
    logic [31:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        lock;
    logic        overrun;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    beat_t exp_b;
    int    checks = 0;
    int    errors = 0;
    int    n;

    always #5 clock = ~clock;
    always @(posedge clock) tog <= ~tog;
    assign muestra = mbase ^ ({4{tog & tog_en}} & 4'b0100);

    medidor_bias_multi #(
        .N_CH(4), .OUT_WIDTH(32), .MAX_RESOL(6), .RES_W(5), .SYNC_STAGES(2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .continuo  (continuo),
        .muestra   (muestra),
        .resol     (resol),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lock      (lock),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        sb.push_back('{ch: 2'd0, data: 32'(a)});
        sb.push_back('{ch: 2'd1, data: 32'(b)});
        sb.push_back('{ch: 2'd2, data: 32'(c)});
        sb.push_back('{ch: 2'd3, data: 32'(d)});
    endtask

    task automatic wait_valid(input int maxc, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < maxc) begin
            tick();
            cyc++;
        end
        chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain(input int maxc);
        int k;
        k = 0;
        while (sb.size() != 0 && k < maxc) begin
            tick();
            k++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic restart(input logic [3:0] m, input logic [4:0] r, input logic cont, input logic rdy);
        enable = 1'b0;
        tick();
        mbase     = m;
        resol     = r;
        continuo  = cont;
        out_ready = rdy;
        repeat (3) tick();
    endtask

    // Scoreboard: every accepted beat must match the next expected one.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed beat ch%0d=%0d expected none", out_ch, out_data);
            end
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                chk("beat_ch", 32'(out_ch), 32'(exp_b.ch));
                chk("beat_data", out_data, exp_b.data);
            end
        end
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; continuo = 1'b0; mbase = 4'b0;
        tog_en = 1'b0; resol = 5'd0; out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;

        // Single shot, resol=4, ch0 constant one.
        restart(4'b0001, 5'd4, 1'b0, 1'b1);
        push4(16, 0, 0, 0);
        enable = 1'b1;
        wait_valid(100, n);
        chk("t1_latency", 32'(n), 32'd17);
        chk("t1_lock", 32'(lock), 32'd1);
        n = 0;
        while (out_valid && n < 20) begin
            n++;
            tick();
        end
        chk("t1_valid_cycles", 32'(n), 32'd4);
        repeat (3) tick();
        chk("t1_done_valid", 32'(out_valid), 32'd0);
        chk("t1_done_lock", 32'(lock), 32'd1);
        wait_drain(1);

        // Channel 2 toggling every cycle, resol=3.
        restart(4'b0000, 5'd3, 1'b0, 1'b1);
        tog_en = 1'b1;
        repeat (2) tick();
        push4(0, 0, 4, 0);
        enable = 1'b1;
        wait_valid(100, n);
        wait_drain(20);
        tog_en = 1'b0;

        // resol=0: one-cycle window.
        restart(4'b1111, 5'd0, 1'b0, 1'b1);
        push4(1, 1, 1, 1);
        enable = 1'b1;
        wait_valid(100, n);
        wait_drain(20);

        // Backpressure held on beat ch1.
        restart(4'b1010, 5'd2, 1'b0, 1'b0);
        push4(0, 4, 0, 4);
        enable = 1'b1;
        wait_valid(100, n);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ch_hold", 32'(out_ch), 32'd1);
            chk("bp_data_hold", out_data, 32'd4);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_drain(20);

        // Continuous with stalled consumer: overrun, first set survives.
        restart(4'b0011, 5'd2, 1'b1, 1'b0);
        push4(4, 4, 0, 0);
        enable = 1'b1;
        wait_valid(100, n);
        chk("ovr_clear_first", 32'(overrun), 32'd0);
        mbase = 4'b1100;
        repeat (6) tick();
        chk("ovr_set", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        wait_drain(1);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_lock", 32'(lock), 32'd1);
        enable = 1'b0;
        tick();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_lock", 32'(lock), 32'd0);
        chk("abort_overrun", 32'(overrun), 32'd0);

        // Abort mid-MEASURE, then a fresh measurement.
        restart(4'b0001, 5'd5, 1'b0, 1'b1);
        enable = 1'b1;
        repeat (10) tick();
        restart(4'b0001, 5'd3, 1'b0, 1'b1);
        chk("abort2_valid", 32'(out_valid), 32'd0);
        chk("abort2_lock", 32'(lock), 32'd0);
        push4(8, 0, 0, 0);
        enable = 1'b1;
        wait_valid(100, n);
        chk("fresh_latency", 32'(n), 32'd9);
        wait_drain(20);

        // Asynchronous reset between edges while draining.
        restart(4'b1111, 5'd2, 1'b0, 1'b0);
        enable = 1'b1;
        wait_valid(100, n);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_data", out_data, 32'd0);
        chk("areset_ch", 32'(out_ch), 32'd0);
        chk("areset_lock", 32'(lock), 32'd0);
        chk("areset_overrun", 32'(overrun), 32'd0);
        tick();
        enable  = 1'b0;
        reset_n = 1'b1;
        tick();

        // resol=31 clamps to MAX_RESOL=6: 64-cycle window.
        restart(4'b0101, 5'd31, 1'b0, 1'b1);
        push4(64, 0, 64, 0);
        enable = 1'b1;
        wait_valid(200, n);
        chk("clamp_latency", 32'(n), 32'd65);
        wait_drain(20);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
